hex_display_arbiter: RTL and testbench

//  Shares the 4-digit 7-segment display between NUM_REQ requesters (e.g. PC, IR, MAR, switch echo).

---
 rtl/hex_display_arbiter.sv | 139 +++++++++++++
 tb/tb_hex_display_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the shared 4-digit hex display. A new owner appears one cycle after req.
// An owner under contention keeps the display for DWELL_CYCLES cycles, and releasing req ends ownership at once.
module hex_display_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DWELL_W      = $clog2(DWELL_CYCLES + 1),
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][15:0]      value,
  output logic [NUM_REQ-1:0]            grant,
  output logic [IDX_W-1:0]              owner_idx,
  output logic [3:0][3:0]               disp_nibble,
  output logic                          disp_valid,
  output logic                          switch_pulse
);

  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]   PTR_RST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_idx_q, owner_idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [3:0][3:0]      disp_q, disp_d;
  logic                 disp_valid_q, disp_valid_d;
  logic                 switch_pulse_q, switch_pulse_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [IDX_W-1:0]     win;
  int                   idx;

  // The current owner is masked out so it is never re-granted while others wait.
  always_comb begin
    cand  = req;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (state_q == SHOW) begin
      cand = req & ~grant_q;
    end
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_idx_d    = owner_idx_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    disp_d         = disp_q;
    disp_valid_d   = disp_valid_q;
    switch_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = SHOW;
          grant_d        = NUM_REQ'(1) << win;
          owner_idx_d    = win;
          ptr_d          = win;
          cnt_d          = '0;
          disp_d         = value[win];
          disp_valid_d   = 1'b1;
          switch_pulse_d = 1'b1;
        end
      end
      SHOW: begin
        if (!req[owner_idx_q] || (cnt_q == DWELL_MAX && found)) begin
          if (found) begin
            grant_d        = NUM_REQ'(1) << win;
            owner_idx_d    = win;
            ptr_d          = win;
            cnt_d          = '0;
            disp_d         = value[win];
            switch_pulse_d = 1'b1;
          end else begin
            // Owner released with nobody waiting; the last digits stay on the driver.
            state_d      = IDLE;
            grant_d      = '0;
            disp_valid_d = 1'b0;
          end
        end else begin
          if (cnt_q != DWELL_MAX) begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
          disp_d = value[owner_idx_q];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      owner_idx_q    <= '0;
      ptr_q          <= PTR_RST;
      cnt_q          <= '0;
      disp_q         <= '0;
      disp_valid_q   <= 1'b0;
      switch_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_idx_q    <= owner_idx_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      disp_q         <= disp_d;
      disp_valid_q   <= disp_valid_d;
      switch_pulse_q <= switch_pulse_d;
    end
  end

  assign grant        = grant_q;
  assign owner_idx    = owner_idx_q;
  assign disp_nibble  = disp_q;
  assign disp_valid   = disp_valid_q;
  assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Randomized and directed stimulus for hex_display_arbiter, checked through an expectation queue
// against a cycle-level reference model of the sharing rules.
module tb_hex_display_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0][15:0] value = '0;
  logic [N-1:0]     grant;
  logic [1:0]       owner_idx;
  logic [3:0][3:0]  disp_nibble;
  logic             disp_valid;
  logic             switch_pulse;

  hex_display_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .req(req), .value(value),
    .grant(grant), .owner_idx(owner_idx), .disp_nibble(disp_nibble),
    .disp_valid(disp_valid), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [1:0]   idx;
    logic [15:0]  disp;
    logic         valid;
    logic         pulse;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit stim_done = 0;

  // Reference model: who owns the display, how long it has held it, and who was served last.
  int          m_owner = -1;
  int          m_last = N - 1;
  int          m_held = 0;
  int          m_idx = 0;
  logic [15:0] m_disp = '0;
  logic        m_pulse = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] cand, input int last);
    for (int k = 1; k <= N; k++) begin
      if (cand[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic give_to(input int w);
    m_owner = w;
    m_last  = w;
    m_idx   = w;
    m_held  = 0;
    m_disp  = value[w];
    m_pulse = 1'b1;
  endtask

  task automatic model_step();
    exp_t e;
    int w;
    logic [N-1:0] others;
    if (reset) begin
      m_owner = -1; m_last = N - 1; m_held = 0; m_idx = 0; m_disp = '0; m_pulse = 1'b0;
    end else if (m_owner < 0) begin
      w = rr_pick(req, m_last);
      if (w >= 0) give_to(w);
      else m_pulse = 1'b0;
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      w = rr_pick(others, m_last);
      if (!req[m_owner]) begin
        if (w >= 0) give_to(w);
        else begin m_owner = -1; m_pulse = 1'b0; end
      end else if (m_held >= D - 1 && w >= 0) begin
        give_to(w);
      end else begin
        if (m_held < D - 1) m_held++;
        m_disp  = value[m_owner];
        m_pulse = 1'b0;
      end
    end
    e.grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e.idx   = 2'(m_idx);
    e.disp  = m_disp;
    e.valid = (m_owner >= 0);
    e.pulse = m_pulse;
    e.cyc   = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0][15:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      reset = r;
      req   = rq;
      value = v;
      model_step();
    end
  endtask

  task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  // Monitor: the DUT presents a registered result every cycle; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant",        e.cyc, 16'(grant),       16'(e.grant));
        chk("owner_idx",    e.cyc, 16'(owner_idx),   16'(e.idx));
        chk("disp_nibble",  e.cyc, disp_nibble,      e.disp);
        chk("disp_valid",   e.cyc, 16'(disp_valid),  16'(e.valid));
        chk("switch_pulse", e.cyc, 16'(switch_pulse), 16'(e.pulse));
        chk("grant_onehot0", e.cyc, 16'($onehot0(grant)), 16'd1);
      end
    end
  end

  initial begin
    logic [N-1:0][15:0] v;
    logic [N-1:0] rq;
    v = '0;
    // Reset and first grant of BEEF to requester 1, then release to idle
    drive(1'b1, 4'b0000, v, 3);
    v[1] = 16'hBEEF;
    drive(1'b0, 4'b0010, v, 3);
    drive(1'b0, 4'b0000, v, 3);
    // Full contention from idle
    v = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    drive(1'b1, 4'b0000, v, 1);
    drive(1'b0, 4'b1111, v, 20);
    // Owner release ahead of dwell expiry, then last owner releases
    drive(1'b1, 4'b0000, v, 1);
    drive(1'b0, 4'b0011, v, 2);
    drive(1'b0, 4'b0010, v, 3);
    drive(1'b0, 4'b0000, v, 3);
    // Live value update under a single owner
    v[2] = 16'h1234;
    drive(1'b0, 4'b0100, v, 3);
    v[2] = 16'h5678;
    drive(1'b0, 4'b0100, v, 3);
    // Late contender wraps from 3 to 0
    drive(1'b0, 4'b1000, v, 12);
    drive(1'b0, 4'b1001, v, 6);
    // Reset while showing, then contention restarts at requester 0
    drive(1'b0, 4'b0100, v, 3);
    drive(1'b1, 4'b0100, v, 1);
    drive(1'b0, 4'b1111, v, 8);
    // Randomized traffic with occasional resets
    rq = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) v[k] = 16'($urandom);
      end
      drive(($urandom_range(0, 199) == 0), rq, v, 1);
    end
    stim_done = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", cyc, 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
